regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Merges single-cycle results (ALU/load) and long-latency results (mul/div) onto the register file's single write port.
//  Sits directly upstream of the register file; drives its RegWrite / WriteRegister / WriteData inputs.
//  Long-latency results are buffered in a small FIFO and drain on idle primary cycles.
//  A busy-register scoreboard is exported so the issue stage can stall on RAW/WAW against pending long ops.
// PARAMETERS
//  DEPTH       4   long-result FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   cycles a non-empty FIFO head may wait before the arbiter requests a primary stall
// PORTS
//  iCLK            in   1   core clock; all state updates on posedge
//  iRST_N          in   1   reset, asynchronous assert, active-low
//  iPrimWrite      in   1   primary result valid this cycle (always accepted)
//  iPrimRd         in   5   primary destination register
//  iPrimData       in   32  primary result
//  iSecValid       in   1   long-latency result valid
//  iSecRd          in   5   long-latency destination register
//  iSecData        in   32  long-latency result
//  oSecReady       out  1   FIFO can accept iSec* this cycle
//  iIssueLong      in   1   long op issued this cycle; marks iIssueRd busy
//  iIssueRd        in   5   destination of issued long op
//  oBusy           out  32  scoreboard: bit n set = xn has a pending long result
//  oStallPrimary   out  1   upstream must not assert iPrimWrite next cycle
//  oRegWrite       out  1   to register file write enable
//  oWriteRegister  out  5   to register file write address
//  oWriteData      out  32  to register file write data
//  oFifoCount      out  3   entries held, 0..DEPTH (width $clog2(DEPTH)+1)
// BEHAVIOUR
//  Reset (iRST_N=0, async): all outputs 0, FIFO empty, scoreboard 0, starve counter 0; held until release.
//  Outputs oRegWrite/oWriteRegister/oWriteData are registered: input at edge N appears after edge N, written at N+1.
//  Selection each cycle: iPrimWrite=1 -> primary; else FIFO head if non-empty; else iSecValid&&oSecReady -> bypass sec.
//  Bypass: sec taken directly only when FIFO empty and primary idle; it is then not enqueued.
//  Otherwise accepted sec (iSecValid&&oSecReady) is enqueued at tail; enqueue and dequeue in same cycle allowed.
//  oSecReady = (count<DEPTH) || (count==DEPTH && dequeue this cycle); combinational from count and iPrimWrite.
//  Rd==0: primary or sec write to x0 yields oRegWrite=0 that cycle; sec x0 entries still consume/clear normally.
//  Scoreboard: set bit iIssueRd on iIssueLong (rd!=0); clear bit on the cycle its result drives oRegWrite.
//  Same-cycle set and clear of same rd: set wins. Issue to an already-busy rd is illegal (issue stage stalls).
//  Primary write to a busy rd: passed through unmodified; WAW avoidance is the issue stage's job.
//  Starve counter: increments each cycle FIFO non-empty and head not dequeued; clears on dequeue or empty.
//  oStallPrimary = registered (counter >= STARVE_MAX-1 && FIFO non-empty); deasserts cycle after head drains.
//  If iPrimWrite arrives while oStallPrimary=1, primary still wins (no data loss); head waits.
//  Pointers wrap modulo DEPTH; full/empty distinguished by count, not pointer equality.
//  Reset mid-operation: FIFO contents and scoreboard discarded; no write issued on reset cycle.
// STRUCTURE
//  Shared constants (REG_ZERO=5'd0, XLEN=32, default DEPTH/STARVE_MAX) live in the shared config include.
//  Sub-module wb_result_fifo: DEPTH x 37-bit {rd,data} FIFO with push/pop/count, async active-low reset.
//  Top holds arbitration mux, output register, scoreboard, starve counter.
// TESTING
//  Reset: drive iRST_N=0 mid-stream with FIFO at 3 -> oRegWrite=0, oBusy=0, oFifoCount=0 immediately.
//  Primary only: iPrimWrite rd=5 data=0xDEADBEEF -> next cycle oRegWrite=1, rd=5, data=0xDEADBEEF.
//  Bypass: FIFO empty, prim idle, sec rd=7 data=0x12 -> next cycle write x7=0x12, oFifoCount stays 0, oBusy[7] clears.
//  Contention: prim every cycle, 5 sec results rd=8..12 -> FIFO fills to 4, oSecReady=0 on 5th, oStallPrimary after 8 cycles, drain order 8,9,10,11,12.
//  x0 handling: prim rd=0 data=0xFFFFFFFF -> oRegWrite=0; sec rd=0 queued -> dequeued with oRegWrite=0.
//  Scoreboard race: iIssueLong rd=3 same cycle as pending rd=3 result written -> oBusy[3] remains 1.

Source files
------------

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Holds the pending-result entry layout and the busy-mask helper.
package regfile_writeback_arbiter_pkg;

   localparam int         XLEN           = 32;
   localparam logic [4:0] REG_ZERO       = 5'd0;
   localparam int         DEF_DEPTH      = 4;
   localparam int         DEF_STARVE_MAX = 8;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

   // One-hot mask of a destination register; x0 never appears as busy.
   function automatic logic [XLEN-1:0] rd_onehot(input logic [4:0] rd);
      logic [XLEN-1:0] m;
      m = '0;
      if (rd != REG_ZERO) m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of pending long-latency results {rd,data}.
// Ports: iPush/iData enqueue, iPop dequeue, oHead = oldest entry, oCount = entries held.
module wb_result_fifo
   import regfile_writeback_arbiter_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          iCLK,
   input  logic          iRST_N,
   input  logic          iPush,
   input  wb_entry_t     iData,
   input  logic          iPop,
   output wb_entry_t     oHead,
   output logic [CW-1:0] oCount
);

   wb_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({iPush, iPop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iPush) mem_q[wptr_q] <= iData;
   end

   // Pointers wrap naturally (DEPTH is a power of 2); fullness comes from cnt_q.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (iPush) wptr_q <= wptr_q + 1'b1;
         if (iPop)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   assign oHead  = mem_q[rptr_q];
   assign oCount = cnt_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges primary (ALU/load) and long-latency (mul/div) results onto the
// single register-file write port; exports a busy-register scoreboard.
// Ports: iPrim* primary result, iSec*/oSecReady long result handshake,
// iIssueLong/iIssueRd mark busy, oBusy scoreboard, oStallPrimary starvation
// request, oRegWrite/oWriteRegister/oWriteData register-file port, oFifoCount.
module regfile_writeback_arbiter
   import regfile_writeback_arbiter_pkg::*;
#(
   parameter  int DEPTH      = DEF_DEPTH,
   parameter  int STARVE_MAX = DEF_STARVE_MAX,
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic            iPrimWrite,
   input  logic [4:0]      iPrimRd,
   input  logic [XLEN-1:0] iPrimData,
   input  logic            iSecValid,
   input  logic [4:0]      iSecRd,
   input  logic [XLEN-1:0] iSecData,
   output logic            oSecReady,
   input  logic            iIssueLong,
   input  logic [4:0]      iIssueRd,
   output logic [XLEN-1:0] oBusy,
   output logic            oStallPrimary,
   output logic            oRegWrite,
   output logic [4:0]      oWriteRegister,
   output logic [XLEN-1:0] oWriteData,
   output logic [CW-1:0]   oFifoCount
);

   localparam int              SW         = $clog2(STARVE_MAX) + 1;
   localparam logic [CW-1:0]   FULL       = CW'(DEPTH);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX - 1);

   wb_entry_t       head;
   wb_entry_t       sec_e;
   wb_entry_t       sel;
   logic [CW-1:0]   count;
   logic            empty;
   logic            deq;
   logic            sec_acc;
   logic            bypass;
   logic            push;
   logic            sel_v;
   logic            sel_sec;

   logic            wr_q,    wr_d;
   logic [4:0]      wreg_q,  wreg_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] busy_q,  busy_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            stall_q, stall_d;

   assign sec_e   = '{rd: iSecRd, data: iSecData};
   assign empty   = (count == '0);
   // The head drains on every cycle the primary port is idle.
   assign deq     = !iPrimWrite && !empty;
   assign oSecReady = (count != FULL) || deq;
   assign sec_acc = iSecValid && oSecReady;
   // Skip the FIFO when nothing else wants the port.
   assign bypass  = sec_acc && !iPrimWrite && empty;
   assign push    = sec_acc && !bypass;

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iPush  (push),
      .iData  (sec_e),
      .iPop   (deq),
      .oHead  (head),
      .oCount (count)
   );

   always_comb begin
      sel     = '0;
      sel_v   = 1'b0;
      sel_sec = 1'b0;
      unique case (1'b1)
         iPrimWrite: begin
            sel   = '{rd: iPrimRd, data: iPrimData};
            sel_v = 1'b1;
         end
         deq: begin
            sel     = head;
            sel_v   = 1'b1;
            sel_sec = 1'b1;
         end
         bypass: begin
            sel     = sec_e;
            sel_v   = 1'b1;
            sel_sec = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_d    = sel_v && (sel.rd != REG_ZERO);
      wreg_d  = sel.rd;
      wdata_d = sel.data;
      // A new issue to the same rd outranks the completing write.
      busy_d  = busy_q;
      if (sel_sec)    busy_d = busy_d & ~rd_onehot(sel.rd);
      if (iIssueLong) busy_d = busy_d | rd_onehot(iIssueRd);
      starve_d = starve_q;
      if (empty || deq)              starve_d = '0;
      else if (starve_q < STARVE_LIM) starve_d = starve_q + 1'b1;
      stall_d = (starve_q >= STARVE_LIM) && !empty && !deq;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         wr_q     <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         busy_q   <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   assign oRegWrite      = wr_q;
   assign oWriteRegister = wreg_q;
   assign oWriteData     = wdata_q;
   assign oBusy          = busy_q;
   assign oStallPrimary  = stall_q;
   assign oFifoCount     = count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter.
// Reference model: a result queue, a busy mask and a head-age counter.
module tb_regfile_writeback_arbiter;

   localparam int DEPTH = 4;
   localparam int SM    = 8;

   logic        clk;
   logic        rst_n;
   logic        prim_w;
   logic [4:0]  prim_rd;
   logic [31:0] prim_d;
   logic        sec_v;
   logic [4:0]  sec_rd;
   logic [31:0] sec_d;
   logic        sec_rdy;
   logic        iss;
   logic [4:0]  iss_rd;
   logic [31:0] busy;
   logic        stall;
   logic        rw;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic [2:0]  fcnt;

   int checks = 0;
   int errors = 0;

   logic [36:0] mq[$];
   logic [31:0] mbusy;
   int          head_age;
   logic        mstall;
   logic        last_acc;

   regfile_writeback_arbiter dut (
      .iCLK           (clk),
      .iRST_N         (rst_n),
      .iPrimWrite     (prim_w),
      .iPrimRd        (prim_rd),
      .iPrimData      (prim_d),
      .iSecValid      (sec_v),
      .iSecRd         (sec_rd),
      .iSecData       (sec_d),
      .oSecReady      (sec_rdy),
      .iIssueLong     (iss),
      .iIssueRd       (iss_rd),
      .oBusy          (busy),
      .oStallPrimary  (stall),
      .oRegWrite      (rw),
      .oWriteRegister (wreg),
      .oWriteData     (wdata),
      .oFifoCount     (fcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      prim_w = 0; prim_rd = 0; prim_d = 0;
      sec_v = 0; sec_rd = 0; sec_d = 0;
      iss = 0; iss_rd = 0;
   endtask

   task automatic model_reset();
      mq.delete();
      mbusy = '0;
      head_age = 0;
      mstall = 0;
   endtask

   // One clock: model the cycle from the current inputs, then compare.
   task automatic cycle();
      logic ready, acc, popped, secw, wr;
      logic [4:0] wrd;
      logic [31:0] wdat;
      logic [36:0] e;
      int had;
      #1;
      ready = (mq.size() < DEPTH) || !prim_w;
      checks++;
      if (sec_rdy !== ready) begin
         errors++;
         $display("FAIL sec_ready got %b exp %b", sec_rdy, ready);
      end
      acc = sec_v && ready;
      had = mq.size();
      popped = 0; secw = 0; wr = 0; wrd = 0; wdat = 0;
      if (prim_w) begin
         wr = 1; wrd = prim_rd; wdat = prim_d;
      end else if (had > 0) begin
         e = mq.pop_front();
         wr = 1; wrd = e[36:32]; wdat = e[31:0];
         popped = 1; secw = 1;
      end else if (acc) begin
         wr = 1; wrd = sec_rd; wdat = sec_d;
         secw = 1;
         acc = 0;
      end
      if (acc) mq.push_back({sec_rd, sec_d});
      mstall = (head_age >= SM - 1) && had > 0 && !popped;
      head_age = (had == 0 || popped) ? 0 : head_age + 1;
      if (secw && wrd != 0) mbusy[wrd] = 1'b0;
      if (iss && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      last_acc = sec_v && ready;
      @(posedge clk);
      #1;
      checks++;
      if (rw !== (wr && wrd != 0)) begin
         errors++;
         $display("FAIL reg_write got %b exp %b", rw, wr && wrd != 0);
      end
      if (wr && wrd != 0) begin
         checks++;
         if (wreg !== wrd || wdata !== wdat) begin
            errors++;
            $display("FAIL write_port got x%0d=%h exp x%0d=%h",
                     wreg, wdata, wrd, wdat);
         end
      end
      checks++;
      if (busy !== mbusy) begin
         errors++;
         $display("FAIL busy got %h exp %h", busy, mbusy);
      end
      checks++;
      if (fcnt !== 3'(mq.size())) begin
         errors++;
         $display("FAIL fifo_count got %0d exp %0d", fcnt, mq.size());
      end
      checks++;
      if (stall !== mstall) begin
         errors++;
         $display("FAIL stall got %b exp %b", stall, mstall);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      model_reset();
      #2;
      checks++;
      if ({rw, wreg, wdata, busy, fcnt, stall} !== '0) begin
         errors++;
         $display("FAIL reset_state got rw=%b busy=%h cnt=%0d stall=%b",
                  rw, busy, fcnt, stall);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic test_primary();
      idle_inputs();
      prim_w = 1; prim_rd = 5; prim_d = 32'hDEADBEEF;
      cycle();
      checks++;
      if (rw !== 1'b1 || wreg !== 5'd5 || wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL primary got %b x%0d=%h exp 1 x5=deadbeef",
                  rw, wreg, wdata);
      end
      idle_inputs();
      cycle();
   endtask

   task automatic test_bypass();
      idle_inputs();
      iss = 1; iss_rd = 7;
      cycle();
      checks++;
      if (busy[7] !== 1'b1) begin
         errors++;
         $display("FAIL bypass_busy_set got %b exp 1", busy[7]);
      end
      idle_inputs();
      sec_v = 1; sec_rd = 7; sec_d = 32'h12;
      cycle();
      checks++;
      if (rw !== 1'b1 || wreg !== 5'd7 || wdata !== 32'h12
          || fcnt !== 3'd0 || busy[7] !== 1'b0) begin
         errors++;
         $display("FAIL bypass got %b x%0d=%h cnt=%0d busy7=%b exp 1 x7=12 0 0",
                  rw, wreg, wdata, fcnt, busy[7]);
      end
      idle_inputs();
      cycle();
   endtask

   task automatic test_contention();
      logic [4:0] drained[$];
      int nsec = 8;
      int k = 0;
      int stall_k = -1;
      bit prim_on = 1;
      bit seen_full = 0;
      bit seen_nr = 0;
      idle_inputs();
      while (drained.size() < 5 && k < 60) begin
         if (stall) prim_on = 0;
         prim_w = prim_on;
         prim_rd = 5'($urandom_range(31, 13));
         prim_d = $urandom;
         sec_v = (nsec <= 12);
         sec_rd = 5'(nsec);
         sec_d = 32'hA000_0000 + nsec;
         cycle();
         k++;
         if (sec_v && !last_acc && prim_w) seen_nr = 1;
         if (sec_v && last_acc) nsec++;
         if (fcnt == 3'd4) seen_full = 1;
         if (stall && stall_k < 0) stall_k = k;
         if (rw && wreg >= 8 && wreg <= 12) drained.push_back(wreg);
      end
      checks++;
      if (drained.size() != 5) begin
         errors++;
         $display("FAIL contention_timeout got %0d drained exp 5",
                  drained.size());
      end
      foreach (drained[i]) begin
         checks++;
         if (drained[i] !== 5'(8 + i)) begin
            errors++;
            $display("FAIL drain_order[%0d] got %0d exp %0d",
                     i, drained[i], 8 + i);
         end
      end
      checks++;
      if (!seen_full || !seen_nr) begin
         errors++;
         $display("FAIL fifo_full got full=%b notready=%b exp 1 1",
                  seen_full, seen_nr);
      end
      checks++;
      if (stall_k != 9) begin
         errors++;
         $display("FAIL stall_onset got cycle %0d exp 9", stall_k);
      end
      idle_inputs();
      cycle();
   endtask

   task automatic test_x0();
      idle_inputs();
      prim_w = 1; prim_rd = 0; prim_d = 32'hFFFFFFFF;
      cycle();
      checks++;
      if (rw !== 1'b0) begin
         errors++;
         $display("FAIL x0_primary got %b exp 0", rw);
      end
      prim_rd = 20; prim_d = 32'h55;
      sec_v = 1; sec_rd = 0; sec_d = 32'h77;
      cycle();
      checks++;
      if (fcnt !== 3'd1) begin
         errors++;
         $display("FAIL x0_queued got %0d exp 1", fcnt);
      end
      idle_inputs();
      cycle();
      checks++;
      if (rw !== 1'b0 || fcnt !== 3'd0) begin
         errors++;
         $display("FAIL x0_dequeue got rw=%b cnt=%0d exp 0 0", rw, fcnt);
      end
   endtask

   task automatic test_race();
      idle_inputs();
      iss = 1; iss_rd = 3;
      cycle();
      idle_inputs();
      prim_w = 1; prim_rd = 21; prim_d = 32'h1;
      sec_v = 1; sec_rd = 3; sec_d = 32'h333;
      cycle();
      idle_inputs();
      iss = 1; iss_rd = 3;
      cycle();
      checks++;
      if (rw !== 1'b1 || wreg !== 5'd3 || busy[3] !== 1'b1) begin
         errors++;
         $display("FAIL race got rw=%b x%0d busy3=%b exp 1 x3 1",
                  rw, wreg, busy[3]);
      end
      idle_inputs();
      cycle();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      iss = 1; iss_rd = 9;
      cycle();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         prim_w = 1; prim_rd = 22; prim_d = $urandom;
         sec_v = 1; sec_rd = 5'(14 + i); sec_d = $urandom;
         cycle();
      end
      idle_inputs();
      checks++;
      if (fcnt !== 3'd3 || busy === '0) begin
         errors++;
         $display("FAIL reset_setup got cnt=%0d busy=%h exp 3 nonzero",
                  fcnt, busy);
      end
      rst_n = 0;
      #1;
      checks++;
      if (rw !== 1'b0 || busy !== '0 || fcnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid got rw=%b busy=%h cnt=%0d exp 0 0 0",
                  rw, busy, fcnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
      cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         idle_inputs();
         prim_w = ($urandom_range(99) < 50) && !mstall;
         prim_rd = 5'($urandom);
         prim_d = $urandom;
         sec_v = ($urandom_range(99) < 40);
         sec_rd = 5'($urandom);
         sec_d = $urandom;
         iss_rd = 5'($urandom);
         iss = ($urandom_range(99) < 30) && !mbusy[iss_rd];
         cycle();
      end
      idle_inputs();
      for (int n = 0; n < 6; n++) cycle();
   endtask

   initial begin
      test_reset();
      model_reset();
      test_primary();
      test_bypass();
      test_contention();
      test_x0();
      test_race();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
